// File: rtl/load_store_unit.sv
// Load/store unit: one valid/ready data-bus transaction per load or store,
// with store lane steering, load extraction/extension and misalignment trapping.
module load_store_unit (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] lsu_rdata,
  output logic        stall,
  output logic        misaligned,
  output logic        bus_valid,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned NSTRB = XLEN / 8;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic             we_q;
  logic [2:0]       funct3_q;
  logic [1:0]       off_q;

  logic             illegal_c;
  logic [NSTRB-1:0] wstrb_c;
  logic [XLEN-1:0]  wdata_c;
  logic [XLEN-1:0]  shifted_c;
  logic [XLEN-1:0]  load_c;

  // Legality: size/alignment check plus unsigned codes are loads only
  always_comb begin
    illegal_c = 1'b1;
    case (funct3)
      F3_B:    illegal_c = 1'b0;
      F3_H:    illegal_c = addr[0];
      F3_W:    illegal_c = (addr[1:0] != 2'b00);
      F3_BU:   illegal_c = we;
      F3_HU:   illegal_c = we | addr[0];
      default: illegal_c = 1'b1;
    endcase
  end

  // Store lane steering
  always_comb begin
    wstrb_c = 4'b1111;
    wdata_c = wdata;
    case (funct3[1:0])
      2'b00: begin
        wstrb_c = 4'b0001 << addr[1:0];
        wdata_c = {4{wdata[7:0]}};
      end
      2'b01: begin
        wstrb_c = 4'b0011 << addr[1:0];
        wdata_c = {2{wdata[15:0]}};
      end
      default: begin
        wstrb_c = 4'b1111;
        wdata_c = wdata;
      end
    endcase
  end

  // Load extraction from the latched byte offset
  always_comb begin
    shifted_c = bus_rdata >> {off_q, 3'b000};
    load_c    = bus_rdata;
    case (funct3_q)
      F3_B:    load_c = {{24{shifted_c[7]}}, shifted_c[7:0]};
      F3_BU:   load_c = {24'h000000, shifted_c[7:0]};
      F3_H:    load_c = {{16{shifted_c[15]}}, shifted_c[15:0]};
      F3_HU:   load_c = {16'h0000, shifted_c[15:0]};
      default: load_c = bus_rdata;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = illegal_c ? DONE : BUSY;
      BUSY:    if (bus_ready) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      funct3_q   <= 3'b000;
      off_q      <= 2'b00;
      lsu_rdata  <= '0;
      misaligned <= 1'b0;
      bus_valid  <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wstrb  <= '0;
      bus_wdata  <= '0;
    end else begin
      state_q    <= state_d;
      misaligned <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            if (illegal_c) begin
              misaligned <= 1'b1;
              lsu_rdata  <= '0;
            end else begin
              we_q      <= we;
              funct3_q  <= funct3;
              off_q     <= addr[1:0];
              bus_valid <= 1'b1;
              bus_we    <= we;
              bus_addr  <= {addr[31:2], 2'b00};
              bus_wstrb <= we ? wstrb_c : 4'b0000;
              bus_wdata <= we ? wdata_c : 32'h0;
            end
          end
        end
        BUSY: begin
          if (bus_ready) begin
            bus_valid <= 1'b0;
            lsu_rdata <= we_q ? 32'h0 : load_c;
          end
        end
        default: ;
      endcase
    end
  end

  // Combinational so the access stalls in the cycle req arrives
  assign stall = rstn & req & (state_q != DONE);

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit between the execute stage and the data memory bus. It takes the ALU-computed effective address, the store data and funct3, and runs one valid/ready bus transaction. For stores it generates byte strobes and lane-replicated write data. For loads it extracts and sign- or zero-extends the addressed byte, halfword or word into the registered `lsu_rdata` that the writeback mux selects for loads. It stalls the pipeline for the whole access and flags misaligned accesses without touching the bus.

## Interface
- No parameters. Data and address width is fixed at 32 bits.
- `clk` in 1: core clock, rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `req` in 1: a load or store is in execute. Held high until `stall` falls.
- `we` in 1: 1 = store, 0 = load. Valid while `req` is high.
- `funct3` in 3: access size and sign. 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU. Any other code is illegal.
- `addr` in 32: effective byte address (main ALU result).
- `wdata` in 32: store data (rs2).
- `lsu_rdata` out 32: formatted load result, registered.
- `stall` out 1: hold the pipeline.
- `misaligned` out 1: one-cycle exception flag for a misaligned or illegal access.
- `bus_valid` out 1: bus request valid.
- `bus_we` out 1: bus write enable.
- `bus_addr` out 32: word-aligned address, `{addr[31:2],2'b00}`.
- `bus_wstrb` out 4: byte write strobes.
- `bus_wdata` out 32: lane-replicated store data.
- `bus_ready` in 1: bus accepts or completes the transfer.
- `bus_rdata` in 32: read word. Valid in the cycle `bus_valid && bus_ready`.

## Operation
- FSM states: IDLE, BUSY, DONE.
- **IDLE, `req` high, access legal:** latch `we`, `funct3`, `addr[1:0]` and all `bus_*` values into registers, then go to BUSY.
- **IDLE, `req` high, access illegal:** go to DONE with `misaligned` = 1, `lsu_rdata` = 0, and no bus transaction. An access is illegal when:
  - it is a halfword access and `addr[0]` = 1,
  - it is a word access and `addr[1:0]` ≠ 0, or
  - `funct3` is an illegal code (011, 110, 111, or any of 1xx for a store).
- **BUSY:** `bus_valid` = 1 and every `bus_*` output is held stable. On `bus_ready`, register the formatted load data, or 0 for a store, into `lsu_rdata`, then go to DONE.
- **DONE:** go to IDLE unconditionally. The `req` seen in DONE belongs to the finishing instruction and must not start a new access.
- `stall` = `req && state != DONE`. It is forced to 0 while `rstn` is low.
- Store strobes and data, with `o` = `addr[1:0]`:
  - SB: `bus_wstrb` = `4'b0001 << o`, `bus_wdata` = `{4{wdata[7:0]}}`.
  - SH: `bus_wstrb` = `4'b0011 << o`, `bus_wdata` = `{2{wdata[15:0]}}`.
  - SW: `bus_wstrb` = `4'b1111`, `bus_wdata` = `wdata`.
- Loads drive `bus_wstrb` = 0 and `bus_we` = 0.
- Load formatting: `s = bus_rdata >> (8*o)`.
  - LB: sign-extend `s[7:0]`. LBU: zero-extend `s[7:0]`.
  - LH: sign-extend `s[15:0]`. LHU: zero-extend `s[15:0]`.
  - LW: `bus_rdata`.
- `lsu_rdata` holds its value until the next completed access.

## Timing
- Reset values (asynchronous, immediate on `rstn` low):
  - state = IDLE.
  - `lsu_rdata`, `bus_addr`, `bus_wdata` = 0.
  - `bus_wstrb` = 0.
  - `bus_valid`, `bus_we`, `misaligned` = 0.
- Reset mid-transaction abandons the access and drops `bus_valid` the same instant. There is no retry after reset.
- Legal access, with `req` rising in cycle 0:
  - Cycles 0 and 1: `stall` = 1. `bus_valid` = 1 from cycle 1.
  - If `bus_ready` = 1 in cycle 1: cycle 2 is DONE, with `stall` = 0 and `lsu_rdata` valid. This is the minimum of 2 stall cycles.
  - Each additional cycle with `bus_ready` = 0 adds exactly one stall cycle.
- `bus_valid` never drops before the handshake completes and is 0 in DONE. A single transfer is never repeated.
- Illegal access: cycle 0 stalls. Cycle 1 is DONE with `misaligned` = 1 for exactly one cycle and `stall` = 0.
- Back-to-back accesses: a new `req` is sampled in the IDLE cycle after DONE, with no bubble beyond DONE→IDLE.
- `bus_ready` outside BUSY is ignored.

## Test plan
- **LW, word-aligned:** `addr` = 0x1000, `bus_rdata` = 0xDEADBEEF, `bus_ready` = 1 in the first BUSY cycle → `bus_addr` = 0x1000, exactly 2 stall cycles, `lsu_rdata` = 0xDEADBEEF in DONE.
- **LB and LBU at `addr` = 0x1003,** with `bus_rdata` = 0x80FF7F01 → LB gives `lsu_rdata` = 0xFFFFFF80; LBU gives 0x00000080.
- **SH at `addr` = 0x2002,** with `wdata` = 0x1234ABCD → `bus_wstrb` = 1100, `bus_wdata` = 0xABCDABCD, `bus_we` = 1, `lsu_rdata` = 0.
- **LW with `bus_ready` held low for 3 BUSY cycles:** `bus_*` outputs stable throughout → 5 stall cycles total, single transfer, `bus_valid` = 0 in DONE.
- **LW at `addr` = 0x1002:** no `bus_valid` pulse; `misaligned` = 1 for one cycle; 1 stall cycle.
- **`rstn` asserted low mid-BUSY:** `bus_valid` = 0, `stall` = 0 and state IDLE immediately. After release, the next `req` runs a normal transaction.
